// File: rtl/ctrl_pkg.sv
// Shared opcode encodings, FSM state type and fixed decode constants
// for the pipelined control unit.
package ctrl_pkg;

    localparam logic [3:0] OP_WRALL = 4'b1000;
    localparam logic [3:0] OP_DIRV  = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_SHIFT = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_EOP   = 4'b1111;

    localparam logic [3:0] ALU_SEL_NOP = 4'b0111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder; produces the control word that the
// pipeline register captures when an instruction is accepted.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int CFG_W = 2
) (
    input  logic [3:0]       i_op,
    input  logic             i_ctrl,
    input  logic [CFG_W-1:0] i_re_config,
    output logic [CFG_W-1:0] o_reg_wr,
    output logic             o_mem_wr,
    output logic             o_wr_bk_sel,
    output logic             o_ctrl_sel,
    output logic             o_jmp,
    output logic             o_eop,
    output logic [1:0]       o_dir_val,
    output logic [3:0]       o_alu_sel
);

    logic w_is_wrall;
    logic w_is_dirv;
    logic w_is_load;
    logic w_is_store;
    logic w_is_shift;
    logic w_is_jmp;
    logic w_is_nop;
    logic w_is_eop;
    logic w_no_wb;

    assign w_is_wrall = (i_op == OP_WRALL);
    assign w_is_dirv  = (i_op == OP_DIRV);
    assign w_is_load  = (i_op == OP_LOAD);
    assign w_is_store = (i_op == OP_STORE);
    assign w_is_shift = (i_op == OP_SHIFT);
    assign w_is_jmp   = (i_op == OP_JMP);
    assign w_is_nop   = (i_op == OP_NOP);
    assign w_is_eop   = (i_op == OP_EOP);

    // Opcodes that never write back to the register file.
    assign w_no_wb = w_is_store | w_is_jmp | w_is_nop | w_is_eop;

    assign o_reg_wr    = (w_is_wrall ? {CFG_W{1'b1}} : i_re_config) & ~{CFG_W{w_no_wb}};
    assign o_mem_wr    = w_is_store;
    assign o_wr_bk_sel = w_is_load;
    assign o_ctrl_sel  = i_ctrl & ~w_is_nop;
    assign o_jmp       = w_is_jmp;
    assign o_eop       = w_is_eop;
    assign o_dir_val   = {w_is_dirv & i_ctrl, w_is_shift};
    assign o_alu_sel   = w_is_nop ? ALU_SEL_NOP : i_op;

endmodule

// File: rtl/control_unit_pipe.sv
// Single-stage control pipeline: registers decoded controls, squashes slots
// after a jump and drains the pipe to a halt after end-of-program.
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int CFG_W        = 2,
    parameter int JMP_FLUSH    = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic             ctrl,
    input  logic [CFG_W-1:0] re_config,
    input  logic             stall,
    output logic             out_valid,
    output logic             jmp,
    output logic             eop,
    output logic             ctrl_sel,
    output logic             mem_wr,
    output logic             wr_bk_sel,
    output logic [CFG_W-1:0] reg_wr,
    output logic [3:0]       alu_sel,
    output logic [1:0]       dir_val,
    output logic             fetch_hold,
    output logic             halted
);

    localparam int CNT_MAX = (JMP_FLUSH > DRAIN_CYCLES) ? JMP_FLUSH : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_JMP   = CNT_W'(JMP_FLUSH);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load;

    logic [CFG_W-1:0] w_reg_wr;
    logic             w_mem_wr;
    logic             w_wr_bk_sel;
    logic             w_ctrl_sel;
    logic             w_jmp;
    logic             w_eop;
    logic [1:0]       w_dir_val;
    logic [3:0]       w_alu_sel;

    logic             r_out_valid;
    logic             r_jmp;
    logic             r_eop;
    logic             r_ctrl_sel;
    logic             r_mem_wr;
    logic             r_wr_bk_sel;
    logic [CFG_W-1:0] r_reg_wr;
    logic [3:0]       r_alu_sel;
    logic [1:0]       r_dir_val;
    logic             r_fetch_hold;
    logic             r_halted;

    control_decode #(.CFG_W(CFG_W)) u_decode (
        .i_op        (op),
        .i_ctrl      (ctrl),
        .i_re_config (re_config),
        .o_reg_wr    (w_reg_wr),
        .o_mem_wr    (w_mem_wr),
        .o_wr_bk_sel (w_wr_bk_sel),
        .o_ctrl_sel  (w_ctrl_sel),
        .o_jmp       (w_jmp),
        .o_eop       (w_eop),
        .o_dir_val   (w_dir_val),
        .o_alu_sel   (w_alu_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            RUN: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    if (w_jmp && (JMP_FLUSH > 0)) begin
                        w_state_nxt = SQUASH;
                        w_cnt_nxt   = CNT_JMP;
                    end else if (w_eop) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = CNT_DRAIN;
                    end
                end
            end
            // Only slots that actually carry an instruction consume the flush budget.
            SQUASH: begin
                if (in_valid) begin
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
            end
            DRAIN: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = HALTED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_jmp        <= 1'b0;
            r_eop        <= 1'b0;
            r_ctrl_sel   <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_wr_bk_sel  <= 1'b0;
            r_reg_wr     <= '0;
            r_alu_sel    <= '0;
            r_dir_val    <= '0;
            r_fetch_hold <= 1'b0;
            r_halted     <= 1'b0;
        end else if (!stall) begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_valid  <= w_load;
            r_jmp        <= w_load & w_jmp;
            r_eop        <= w_load & w_eop;
            r_ctrl_sel   <= w_load & w_ctrl_sel;
            r_mem_wr     <= w_load & w_mem_wr;
            r_wr_bk_sel  <= w_load & w_wr_bk_sel;
            r_reg_wr     <= w_load ? w_reg_wr : '0;
            r_alu_sel    <= w_load ? w_alu_sel : '0;
            r_dir_val    <= w_load ? w_dir_val : '0;
            r_fetch_hold <= (w_state_nxt == DRAIN) || (w_state_nxt == HALTED);
            r_halted     <= (w_state_nxt == HALTED);
        end
    end

    assign out_valid  = r_out_valid;
    assign jmp        = r_jmp;
    assign eop        = r_eop;
    assign ctrl_sel   = r_ctrl_sel;
    assign mem_wr     = r_mem_wr;
    assign wr_bk_sel  = r_wr_bk_sel;
    assign reg_wr     = r_reg_wr;
    assign alu_sel    = r_alu_sel;
    assign dir_val    = r_dir_val;
    assign fetch_hold = r_fetch_hold;
    assign halted     = r_halted;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed scenarios plus randomized traffic against a slot-level model of
// the control unit (decode table, squash budget, drain countdown).
module tb_control_unit_pipe;

    localparam int CFG_W        = 2;
    localparam int JMP_FLUSH    = 2;
    localparam int DRAIN_CYCLES = 4;

    localparam logic [3:0] OP_WRALL = 4'b1000;
    localparam logic [3:0] OP_DIRV  = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_SHIFT = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_EOP   = 4'b1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [3:0]       op = 4'd0;
    logic             ctrl = 1'b0;
    logic [CFG_W-1:0] re_config = '0;
    logic             stall = 1'b0;
    logic             out_valid, jmp, eop, ctrl_sel, mem_wr, wr_bk_sel;
    logic [CFG_W-1:0] reg_wr;
    logic [3:0]       alu_sel;
    logic [1:0]       dir_val;
    logic             fetch_hold, halted;

    control_unit_pipe #(
        .CFG_W(CFG_W), .JMP_FLUSH(JMP_FLUSH), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .ctrl(ctrl),
        .re_config(re_config), .stall(stall), .out_valid(out_valid), .jmp(jmp),
        .eop(eop), .ctrl_sel(ctrl_sel), .mem_wr(mem_wr), .wr_bk_sel(wr_bk_sel),
        .reg_wr(reg_wr), .alu_sel(alu_sel), .dir_val(dir_val),
        .fetch_hold(fetch_hold), .halted(halted)
    );

    logic [15:0] obs;
    assign obs = {out_valid, jmp, eop, ctrl_sel, mem_wr, wr_bk_sel, reg_wr,
                  alu_sel, dir_val, fetch_hold, halted};

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: remaining squash slots, remaining drain cycles, halt flag.
    int          m_squash_left = 0;
    int          m_drain_left  = 0;
    bit          m_draining    = 1'b0;
    bit          m_halted      = 1'b0;
    logic [15:0] m_exp         = 16'h0000;

    function automatic logic [15:0] ref_decode(input logic [3:0] o, input logic c,
                                               input logic [1:0] cfg);
        logic [1:0] rw;
        logic [3:0] alu;
        logic [1:0] dv;
        logic       j, e, cs, mw, wb;
        rw = cfg; alu = o; dv = 2'b00; j = 0; e = 0; cs = c; mw = 0; wb = 0;
        case (o)
            OP_WRALL: rw = 2'b11;
            OP_DIRV:  dv[1] = c;
            OP_LOAD:  wb = 1'b1;
            OP_STORE: begin mw = 1'b1; rw = 2'b00; end
            OP_SHIFT: dv[0] = 1'b1;
            OP_JMP:   begin j = 1'b1; rw = 2'b00; end
            OP_NOP:   begin alu = 4'b0111; cs = 1'b0; rw = 2'b00; end
            OP_EOP:   begin e = 1'b1; rw = 2'b00; end
            default:  ;
        endcase
        return {1'b1, j, e, cs, mw, wb, rw, alu, dv, 2'b00};
    endfunction

    task automatic model_step();
        logic [15:0] o;
        if (rst) begin
            m_squash_left = 0; m_drain_left = 0;
            m_draining = 1'b0; m_halted = 1'b0; m_exp = 16'h0000;
            return;
        end
        if (stall) return;
        o = 16'h0000;
        if (m_halted) begin
        end else if (m_draining) begin
            m_drain_left = m_drain_left - 1;
            if (m_drain_left == 0) begin
                m_draining = 1'b0;
                m_halted   = 1'b1;
            end
        end else if (m_squash_left > 0) begin
            if (in_valid) m_squash_left = m_squash_left - 1;
        end else if (in_valid) begin
            o = ref_decode(op, ctrl, re_config);
            if (op == OP_JMP) m_squash_left = JMP_FLUSH;
            if (op == OP_EOP) begin
                m_draining   = 1'b1;
                m_drain_left = DRAIN_CYCLES;
            end
        end
        o[1] = m_draining || m_halted;
        o[0] = m_halted;
        m_exp = o;
    endtask

    task automatic tick(input logic r, input logic iv, input logic [3:0] o,
                        input logic c, input logic [1:0] cfg, input logic s);
        rst = r; in_valid = iv; op = o; ctrl = c; re_config = cfg; stall = s;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, OP_WRALL, 1'b1, 2'b11, 1'b1);
        n_total++; if (obs !== 16'h0000) $display("FAIL reset_outputs: got %h want 0000", obs); else n_pass++;
        tick(1'b0, 1'b0, OP_NOP, 1'b0, 2'b00, 1'b0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL idle_bubble: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_wrall();
        tick(1'b0, 1'b1, OP_WRALL, 1'b0, 2'b01, 1'b0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL wrall_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (reg_wr !== 2'b11) $display("FAIL wrall_reg_wr: got %b want 11", reg_wr); else n_pass++;
        n_total++; if (alu_sel !== 4'b1000) $display("FAIL wrall_alu_sel: got %b want 1000", alu_sel); else n_pass++;
        n_total++; if (mem_wr !== 1'b0) $display("FAIL wrall_mem_wr: got %b want 0", mem_wr); else n_pass++;
    endtask

    task automatic test_nop_dirv();
        tick(1'b0, 1'b1, OP_NOP, 1'b1, 2'b11, 1'b0);
        n_total++; if (ctrl_sel !== 1'b0) $display("FAIL nop_ctrl_sel: got %b want 0", ctrl_sel); else n_pass++;
        n_total++; if (alu_sel !== 4'b0111) $display("FAIL nop_alu_sel: got %b want 0111", alu_sel); else n_pass++;
        n_total++; if (reg_wr !== 2'b00) $display("FAIL nop_reg_wr: got %b want 00", reg_wr); else n_pass++;
        tick(1'b0, 1'b1, OP_DIRV, 1'b1, 2'b10, 1'b0);
        n_total++; if (dir_val !== 2'b10) $display("FAIL dirv_dir_val: got %b want 10", dir_val); else n_pass++;
        n_total++; if (ctrl_sel !== 1'b1) $display("FAIL dirv_ctrl_sel: got %b want 1", ctrl_sel); else n_pass++;
        tick(1'b0, 1'b1, OP_SHIFT, 1'b0, 2'b01, 1'b0);
        n_total++; if (dir_val !== 2'b01) $display("FAIL shift_dir_val: got %b want 01", dir_val); else n_pass++;
    endtask

    task automatic test_jump_squash();
        tick(1'b0, 1'b1, OP_JMP, 1'b0, 2'b11, 1'b0);
        n_total++; if (jmp !== 1'b1) $display("FAIL jmp_pulse: got %b want 1", jmp); else n_pass++;
        tick(1'b0, 1'b1, OP_STORE, 1'b0, 2'b00, 1'b0);
        n_total++; if (out_valid !== 1'b0 || jmp !== 1'b0) $display("FAIL squash_slot1: got valid=%b jmp=%b want 0 0", out_valid, jmp); else n_pass++;
        tick(1'b0, 1'b1, OP_STORE, 1'b0, 2'b00, 1'b0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL squash_slot2: got %b want 0", out_valid); else n_pass++;
        tick(1'b0, 1'b1, OP_STORE, 1'b0, 2'b00, 1'b0);
        n_total++; if (mem_wr !== 1'b1 || out_valid !== 1'b1) $display("FAIL store_after_squash: got mem_wr=%b valid=%b want 1 1", mem_wr, out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        int bubbles;
        tick(1'b0, 1'b1, OP_LOAD, 1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, OP_JMP, 1'b0, 2'b00, 1'b1);
            n_total++; if (wr_bk_sel !== 1'b1 || out_valid !== 1'b1) $display("FAIL stall_hold_load%0d: got wr_bk_sel=%b valid=%b want 1 1", i, wr_bk_sel, out_valid); else n_pass++;
        end
        tick(1'b0, 1'b1, OP_JMP, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, OP_STORE, 1'b0, 2'b00, 1'b1);
        bubbles = 0;
        for (int i = 0; i < 4 && mem_wr !== 1'b1; i++) begin
            tick(1'b0, 1'b1, OP_STORE, 1'b0, 2'b00, 1'b0);
            if (out_valid === 1'b0) bubbles++;
        end
        n_total++; if (bubbles != JMP_FLUSH || mem_wr !== 1'b1) $display("FAIL stall_squash_count: got bubbles=%0d mem_wr=%b want %0d 1", bubbles, mem_wr, JMP_FLUSH); else n_pass++;
    endtask

    task automatic test_eop_drain();
        tick(1'b0, 1'b1, OP_EOP, 1'b0, 2'b11, 1'b0);
        n_total++; if (eop !== 1'b1 || fetch_hold !== 1'b1 || reg_wr !== 2'b00) $display("FAIL eop_accept: got eop=%b hold=%b reg_wr=%b want 1 1 00", eop, fetch_hold, reg_wr); else n_pass++;
        for (int i = 1; i <= DRAIN_CYCLES; i++) begin
            tick(1'b0, 1'b1, OP_WRALL, 1'b0, 2'b11, 1'b0);
            n_total++;
            if (eop !== 1'b0 || out_valid !== 1'b0 || fetch_hold !== 1'b1 || halted !== (i == DRAIN_CYCLES))
                $display("FAIL drain_cycle%0d: got eop=%b valid=%b hold=%b halted=%b want 0 0 1 %0d", i, eop, out_valid, fetch_hold, halted, (i == DRAIN_CYCLES));
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, OP_WRALL, 1'b1, 2'b11, 1'b0);
            n_total++; if (halted !== 1'b1 || out_valid !== 1'b0) $display("FAIL halted_sticky%0d: got halted=%b valid=%b want 1 0", i, halted, out_valid); else n_pass++;
        end
        tick(1'b1, 1'b0, OP_NOP, 1'b0, 2'b00, 1'b0);
        n_total++; if (obs !== 16'h0000) $display("FAIL halted_reset: got %h want 0000", obs); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        tick(1'b0, 1'b1, OP_EOP, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 1'b0, OP_NOP, 1'b0, 2'b00, 1'b0);
        tick(1'b0, 1'b0, OP_NOP, 1'b0, 2'b00, 1'b0);
        tick(1'b1, 1'b1, OP_WRALL, 1'b1, 2'b11, 1'b1);
        n_total++; if (obs !== 16'h0000) $display("FAIL drain_reset: got %h want 0000", obs); else n_pass++;
        tick(1'b0, 1'b1, OP_WRALL, 1'b0, 2'b00, 1'b0);
        n_total++; if (out_valid !== 1'b1 || reg_wr !== 2'b11 || fetch_hold !== 1'b0) $display("FAIL post_reset_accept: got valid=%b reg_wr=%b hold=%b want 1 11 0", out_valid, reg_wr, fetch_hold); else n_pass++;
    endtask

    task automatic test_random();
        logic       r, iv, c, s;
        logic [3:0] o;
        logic [1:0] cfg;
        int         errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 47) == 0);
            s   = ($urandom_range(0, 4) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            c   = 1'($urandom_range(0, 1));
            cfg = 2'($urandom_range(0, 3));
            o   = 4'($urandom_range(0, 15));
            if (o == OP_EOP && $urandom_range(0, 3) != 0) o = OP_NOP;
            tick(r, iv, o, c, cfg, s);
            n_total++;
            if (obs !== m_exp) begin
                errs++;
                if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, obs, m_exp);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_wrall();
        test_nop_dirv();
        test_jump_squash();
        test_stall();
        test_eop_drain();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
